alu_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares the single 16-bit combinational ALU between two requesters. It accepts one operation at a time over a valid/ready request channel, drives the ALU operand and opcode inputs from internal registers, and captures the result and zero flag. It returns them on a per-requester valid/ready response channel. It sits between the ALU and its clients, such as the execute stage and an address/branch unit.

---
 rtl/alu_pkg.sv | 19 +
 rtl/rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: datapath widths, ALU opcodes
// and the arbiter state encoding.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [OP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the history bit
// (last_grant) is owned by the caller so it can update it only on accept.
module rr_arb2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        o_grant[0] = i_valid0 && (!i_valid1 || i_last_grant);
        o_grant[1] = i_valid1 && (!i_valid0 || !i_last_grant);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 16-bit ALU
// between two requesters. One operation is in flight at a time:
// IDLE (accept) -> ISSUE (ALU evaluates) -> RESP (hold until consumed).
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester
// grant counters on outputs grant_cnt0/grant_cnt1.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    arb_state_t        r_state;
    logic              r_last_grant;
    logic              r_owner;
    logic              r_busy;
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic              r_rsp_zero;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_rsp_result;
    logic [OP_W-1:0]   r_op;

    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_accept0;
    logic              w_accept1;
    logic              w_rsp_done;

    rr_arb2 u_rr_arb2 (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready is a pure decode so a requester sees its grant in the same
    // cycle; it is forced low while reset is held.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];
    assign w_accept0  = req0_valid && req0_ready;
    assign w_accept1  = req1_valid && req1_ready;

    // Only the owner's rsp_ready can retire the response.
    assign w_rsp_done = r_owner ? (r_rsp1_valid && rsp1_ready)
                                : (r_rsp0_valid && rsp0_ready);

    // The ALU always sees the operand registers; its output is only
    // meaningful (and only captured) during ISSUE.
    assign alu_in1    = r_a;
    assign alu_in2    = r_b;
    assign alu_op     = r_op;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign busy       = r_busy;

    // Sequencer FSM with registered busy / response-valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_result <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept0 || w_accept1) begin
                        r_a          <= w_accept1 ? req1_a  : req0_a;
                        r_b          <= w_accept1 ? req1_b  : req0_b;
                        r_op         <= w_accept1 ? req1_op : req0_op;
                        r_owner      <= w_accept1;
                        r_last_grant <= w_accept1;
                        r_busy       <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    // Saturating accept counters, one per requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else begin
            if (w_accept0 && (r_grant_cnt0 != 16'hFFFF)) begin
                r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            end
            if (w_accept1 && (r_grant_cnt1 != 16'hFFFF)) begin
                r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stand-in ALU, directed scenarios
// and a randomized phase. Build with +define+ALU_ARB_STATS_EN to also
// exercise the grant counters.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OP_W-1:0]   req0_op = '0, req1_op = '0;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [DATA_W-1:0] rsp_result, alu_in1, alu_in2, alu_result;
    logic              rsp_zero, alu_zero, busy;
    logic [OP_W-1:0]   alu_op;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]       grant_cnt0, grant_cnt1;
`endif

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the shared combinational ALU.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_result = alu_in1 + alu_in2;
            ALU_SUB: alu_result = alu_in1 - alu_in2;
            ALU_AND: alu_result = alu_in1 & alu_in2;
            default: alu_result = alu_in1 | alu_in2;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        bit          owner;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic [15:0] res;
        bit          zero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference arithmetic: results are taken modulo 2^16.
    function automatic logic [15:0] ref_res(logic [15:0] a, logic [15:0] b, logic [1:0] op);
        int unsigned s;
        case (op)
            2'd0:    s = (int'(a) + int'(b)) % 65536;
            2'd1:    s = (int'(a) - int'(b) + 65536) % 65536;
            2'd2:    s = a & b;
            default: s = a | b;
        endcase
        return s[15:0];
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // ---------------- monitor / reference model ----------------
    int  m_stage = 0;      // 0 idle, 1 ALU cycle, 2 response pending
    bit  m_last  = 1'b1;   // requester served most recently
    bit  e0, e1;
    exp_t e, p;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                {req1_ready, req0_ready, rsp1_valid, rsp0_valid, busy, rsp_zero,
                 rsp_result, alu_in1, alu_in2, alu_op}, 64'd0);
            q.delete();
            m_stage = 0;
            m_last  = 1'b1;
        end else begin
            // Any DUT response handshake retires the oldest expectation.
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    p = q.pop_front();
                    chk("rsp_owner", {rsp1_valid, rsp0_valid}, p.owner ? 2'b10 : 2'b01);
                    chk("rsp_result", rsp_result, p.res);
                    chk("rsp_zero", rsp_zero, p.zero);
                end
            end
            case (m_stage)
                0: begin
                    e0 = req0_valid && (!req1_valid || m_last);
                    e1 = req1_valid && (!req0_valid || !m_last);
                    if (req0_valid || req1_valid)
                        chk("grant", {req1_ready, req0_ready}, {e1, e0});
                    chk("idle_flags", {busy, rsp1_valid, rsp0_valid}, 3'b000);
                    if (e0 || e1) begin
                        e.owner = e1;
                        e.a     = e1 ? req1_a  : req0_a;
                        e.b     = e1 ? req1_b  : req0_b;
                        e.op    = e1 ? req1_op : req0_op;
                        e.res   = ref_res(e.a, e.b, e.op);
                        e.zero  = (e.res == 16'd0);
                        q.push_back(e);
                        m_last  = e1;
                        m_stage = 1;
                    end
                end
                1: begin
                    chk("issue_flags", {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 5'b10000);
                    if (q.size() != 0)
                        chk("alu_inputs", {alu_in1, alu_in2, alu_op}, {q[0].a, q[0].b, q[0].op});
                    m_stage = 2;
                end
                default: begin
                    if (q.size() != 0) begin
                        chk("resp_flags", {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready},
                            {1'b1, q[0].owner, !q[0].owner, 2'b00});
                        chk("resp_stable", {rsp_result, rsp_zero}, {q[0].res, q[0].zero});
                        if (q[0].owner ? rsp1_ready : rsp0_ready) m_stage = 0;
                    end else begin
                        // Expectation already retired by this cycle's handshake.
                        m_stage = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver ----------------
    bit acc0, acc1;

    // One clock: sample handshakes away from the edge, then retire
    // accepted requests just after the edge.
    task automatic step();
        @(negedge clk);
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
    endtask

    task automatic do_reset(int cycles);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic present(bit n, logic [15:0] a, logic [15:0] b, logic [1:0] op);
        if (n) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
    endtask

    task automatic run_quiet(int budget);
        int k = 0;
        while ((req0_valid || req1_valid || busy) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) fail_now("quiet_timeout");
    endtask

    task automatic single(bit n, logic [15:0] a, logic [15:0] b, logic [1:0] op);
        present(n, a, b, op);
        run_quiet(50);
    endtask

    initial begin
        logic [3:0] order;
        int         n_acc;
        int         k;

        do_reset(3);

        // Basic operations, including zero result and subtract wrap.
        single(0, 16'h0003, 16'h0004, ALU_ADD);
        single(1, 16'h1234, 16'h1234, ALU_SUB);
        single(1, 16'h0000, 16'h0001, ALU_SUB);

        // Both requesters continuously valid from reset: 0,1,0,1.
        do_reset(2);
        present(0, 16'hF0F0, 16'h0FF0, ALU_AND);
        present(1, 16'hF000, 16'h000F, ALU_OR);
        order = '0;
        n_acc = 0;
        k = 0;
        while (n_acc < 4 && k < 60) begin
            step();
            k++;
            if (acc0) begin
                order[n_acc] = 1'b0;
                n_acc++;
                if (n_acc < 3) present(0, 16'hF0F0, 16'h0FF0, ALU_AND);
            end
            if (acc1) begin
                order[n_acc] = 1'b1;
                n_acc++;
                if (n_acc < 3) present(1, 16'hF000, 16'h000F, ALU_OR);
            end
        end
        if (n_acc < 4) fail_now("alternate_timeout");
        chk("grant_order", order, 4'b1010);
        run_quiet(50);

        // Owner stalls its response while the other requester waits.
        rsp0_ready = 1'b0;
        present(0, 16'h1111, 16'h2222, ALU_ADD);
        k = 0;
        while (!acc0 && k < 20) begin step(); k++; end
        present(1, 16'h00FF, 16'h0F0F, ALU_AND);
        repeat (6) step();
        chk("stall_busy", {busy, rsp0_valid, req1_ready}, 3'b110);
        rsp0_ready = 1'b1;
        run_quiet(50);

        // Reset during the ALU cycle discards the transaction.
        present(0, 16'hAAAA, 16'h5555, ALU_OR);
        k = 0;
        acc0 = 1'b0;
        while (!acc0 && k < 20) begin step(); k++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        present(0, 16'h0010, 16'h0001, ALU_SUB);
        present(1, 16'h0020, 16'h0002, ALU_SUB);
        run_quiet(60);

        // Randomized traffic with random response back-pressure.
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(2) == 0)
                present(0, 16'($urandom), ($urandom_range(3) == 0) ? req0_a : 16'($urandom),
                        2'($urandom));
            if (!req1_valid && $urandom_range(2) == 0)
                present(1, 16'($urandom), ($urandom_range(3) == 0) ? req1_a : 16'($urandom),
                        2'($urandom));
            rsp0_ready = 1'($urandom);
            rsp1_ready = 1'($urandom);
            step();
        end
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        run_quiet(100);

`ifdef ALU_ARB_STATS_EN
        do_reset(2);
        single(0, 16'd1, 16'd1, ALU_ADD);
        single(1, 16'd2, 16'd2, ALU_ADD);
        single(0, 16'd3, 16'd3, ALU_ADD);
        single(1, 16'd4, 16'd4, ALU_ADD);
        single(0, 16'd5, 16'd5, ALU_ADD);
        chk("grant_cnt0", grant_cnt0, 16'd3);
        chk("grant_cnt1", grant_cnt1, 16'd2);
        force dut.r_grant_cnt0 = 16'hFFFF;
        step();
        release dut.r_grant_cnt0;
        single(0, 16'd6, 16'd6, ALU_ADD);
        chk("grant_cnt0_sat", grant_cnt0, 16'hFFFF);
        chk("grant_cnt1_hold", grant_cnt1, 16'd2);
`endif

        step();
        if (q.size() != 0) fail_now("leftover_expectations");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
